// File: rtl/imm_mem_loader_if.sv
// Stream handshake bundle feeding the immediate memory loader.
// The master drives bytes (header first, then data); the slave returns S_READY.
interface imm_mem_loader_if #(
  parameter int DATA_W = 8
);
  logic              S_VALID;
  logic              S_READY;
  logic [DATA_W-1:0] S_DATA;
  logic              S_LAST;

  modport master (
    output S_VALID,
    output S_DATA,
    output S_LAST,
    input  S_READY
  );

  modport slave (
    input  S_VALID,
    input  S_DATA,
    input  S_LAST,
    output S_READY
  );
endinterface

// File: rtl/imm_mem_loader.sv
// Write-side front end for the 32 x 8 immediate memory.
// Decodes a one-byte header (start address in bits [ADDR_W-1:0]) and writes the
// following data bytes to consecutive addresses, wrapping modulo the depth.
// Optional feature macro: IMM_LOADER_VERIFY_EN adds a read-back check of every
// written byte (IMM_DO / ERR_VFY ports) at a rate of one byte per two cycles.
module imm_mem_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              WCLK,
  input  logic              RSTN,
  imm_mem_loader_if.slave   s_if,
  input  logic              ERR_CLR,
  output logic              IMM_WE,
  output logic [ADDR_W-1:0] IMM_ADDR,
  output logic [DATA_W-1:0] IMM_DIN,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W:0]   WCOUNT,
  output logic              ERR_OVF
`ifdef IMM_LOADER_VERIFY_EN
  ,
  input  logic [DATA_W-1:0] IMM_DO,
  output logic              ERR_VFY
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Word count value meaning "memory full": further data bytes are discarded.
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q,   state_d;
  logic                s_ready_q, s_ready_d;
  logic                we_q,      we_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [DATA_W-1:0]   din_q,     din_d;
  logic [ADDR_W-1:0]   base_q,    base_d;
  logic [ADDR_W:0]     wcount_q,  wcount_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic                err_ovf_q, err_ovf_d;
  logic                xfer_s;
`ifdef IMM_LOADER_VERIFY_EN
  logic                hold_q,      hold_d;
  logic                chk_q,       chk_d;
  logic                pend_last_q, pend_last_d;
  logic                err_vfy_q,   err_vfy_d;
`endif

  assign xfer_s = s_if.S_VALID & s_ready_q;

  // Next-state, write-port and status computation.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    wcount_d  = wcount_q;
    addr_d    = addr_q;
    din_d     = din_q;
    we_d      = 1'b0;
    if (ERR_CLR) begin
      err_ovf_d = 1'b0;
    end else begin
      err_ovf_d = err_ovf_q;
    end
`ifdef IMM_LOADER_VERIFY_EN
    hold_d      = 1'b0;
    chk_d       = 1'b0;
    pend_last_d = pend_last_q;
    if (ERR_CLR) begin
      err_vfy_d = 1'b0;
    end else begin
      err_vfy_d = err_vfy_q;
    end
    // The check cycle sees the completed write with address/data still held.
    if (chk_q && (IMM_DO != din_q)) begin
      err_vfy_d = 1'b1;
    end else begin
      err_vfy_d = err_vfy_d;
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          base_d   = s_if.S_DATA[ADDR_W-1:0];
          wcount_d = '0;
          if (s_if.S_LAST) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
`ifdef IMM_LOADER_VERIFY_EN
        if (hold_q) begin
          // Only bytes that were actually written get read back.
          chk_d = we_q;
          if (pend_last_q) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_DATA;
          end
        end else if (xfer_s) begin
          hold_d      = 1'b1;
          pend_last_d = s_if.S_LAST;
        end else begin
          state_d = ST_DATA;
        end
`else
        if (xfer_s && s_if.S_LAST) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_DATA;
        end
`endif
        if (xfer_s) begin
          if (wcount_q == DEPTH_C) begin
            err_ovf_d = 1'b1;
          end else begin
            we_d     = 1'b1;
            addr_d   = base_q + wcount_q[ADDR_W-1:0];
            din_d    = s_if.S_DATA;
            wcount_d = wcount_q + {{ADDR_W{1'b0}}, 1'b1};
          end
        end else begin
          we_d = 1'b0;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_ready_d = (state_d != ST_FIN);
`ifdef IMM_LOADER_VERIFY_EN
    if (hold_d) begin
      s_ready_d = 1'b0;
    end else begin
      s_ready_d = s_ready_d;
    end
`endif
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge WCLK) begin
    if (!RSTN) begin
      state_q   <= ST_IDLE;
      s_ready_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      base_q    <= '0;
      wcount_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_ovf_q <= 1'b0;
`ifdef IMM_LOADER_VERIFY_EN
      hold_q      <= 1'b0;
      chk_q       <= 1'b0;
      pend_last_q <= 1'b0;
      err_vfy_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      base_q    <= base_d;
      wcount_q  <= wcount_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_ovf_q <= err_ovf_d;
`ifdef IMM_LOADER_VERIFY_EN
      hold_q      <= hold_d;
      chk_q       <= chk_d;
      pend_last_q <= pend_last_d;
      err_vfy_q   <= err_vfy_d;
`endif
    end
  end

  assign s_if.S_READY = s_ready_q;
  assign IMM_WE       = we_q;
  assign IMM_ADDR     = addr_q;
  assign IMM_DIN      = din_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign WCOUNT       = wcount_q;
  assign ERR_OVF      = err_ovf_q;
`ifdef IMM_LOADER_VERIFY_EN
  assign ERR_VFY      = err_vfy_q;
`endif

endmodule
